// File: rtl/ipml_prefetch_sync_fifo_v2_0.sv
// Single-clock first-word-fall-through FIFO: inferred simple-dual-port RAM feeding a small prefetch register buffer.
// Define IPML_PFIFO_ERR_FLAG_EN to build the sticky wr_ovf / rd_udf error flags; otherwise both are tied low.
module ipml_prefetch_sync_fifo_v2_0 #(
    parameter int c_DEPTH_WIDTH    = 10,
    parameter int c_DATA_WIDTH     = 32,
    parameter int c_PREFETCH_DEPTH = 2,
    parameter int c_AF_THRESH      = 1000,
    parameter int c_AE_THRESH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [c_DATA_WIDTH-1:0]  wr_data,
    input  logic                     wr_en,
    output logic                     wr_vld,
    output logic [c_DATA_WIDTH-1:0]  rd_data,
    input  logic                     rd_en,
    output logic                     rd_vld,
    output logic [c_DEPTH_WIDTH:0]   water_level,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     wr_ovf,
    output logic                     rd_udf
);

    localparam int RAM_WORDS = 1 << c_DEPTH_WIDTH;
    localparam int LVL_W     = c_DEPTH_WIDTH + 1;
    localparam int BUF_AW    = $clog2(c_PREFETCH_DEPTH);
    localparam int BUF_CW    = $clog2(c_PREFETCH_DEPTH + 1);

    logic [c_DATA_WIDTH-1:0]  mem [RAM_WORDS];
    logic [c_DEPTH_WIDTH-1:0] wr_ptr;
    logic [c_DEPTH_WIDTH-1:0] rd_ptr;
    logic [LVL_W-1:0]         ram_cnt;
    logic [LVL_W-1:0]         ram_cnt_nxt;
    logic [LVL_W-1:0]         lvl_nxt;

    logic [c_DATA_WIDTH-1:0]  ram_data_p1;
    logic                     vld_p1;

    logic [c_DATA_WIDTH-1:0]  buf_mem [c_PREFETCH_DEPTH];
    logic [BUF_AW-1:0]        head;
    logic [BUF_AW-1:0]        head_nxt;
    logic [BUF_AW-1:0]        tail;
    logic [BUF_CW-1:0]        buf_cnt;
    logic [BUF_CW-1:0]        buf_cnt_nxt;
    logic [BUF_CW:0]          occ;

    logic                     push;
    logic                     pop;
    logic                     fetch;

    // Buffer pointers wrap at c_PREFETCH_DEPTH, which need not be a power of two.
    function automatic logic [BUF_AW-1:0] buf_inc(input logic [BUF_AW-1:0] p);
        return (int'(p) == c_PREFETCH_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign push   = wr_en & wr_vld;
    assign rd_vld = (buf_cnt != '0);
    assign pop    = rd_en & rd_vld;

    // Buffer slots already claimed after this edge: held words plus the read in flight.
    assign occ   = {1'b0, buf_cnt} + {{BUF_CW{1'b0}}, vld_p1} - {{BUF_CW{1'b0}}, pop};
    assign fetch = (ram_cnt != '0) && (int'(occ) < c_PREFETCH_DEPTH);

    always_comb begin
        ram_cnt_nxt = ram_cnt + LVL_W'(push) - LVL_W'(fetch);
        buf_cnt_nxt = buf_cnt + BUF_CW'(vld_p1) - BUF_CW'(pop);
        head_nxt    = pop ? buf_inc(head) : head;
        lvl_nxt     = ram_cnt_nxt + LVL_W'(fetch) + LVL_W'(buf_cnt_nxt);
    end

    assign water_level = ram_cnt + LVL_W'(vld_p1) + LVL_W'(buf_cnt);

    // Stage p0 -> p1: RAM write port and registered read port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
        if (fetch) begin
            ram_data_p1 <= mem[rd_ptr];
        end
    end

    // Stage p1 -> buffer: returning read data lands at the tail.
    always_ff @(posedge clk) begin
        if (vld_p1) begin
            buf_mem[tail] <= ram_data_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            ram_cnt      <= '0;
            vld_p1       <= 1'b0;
            head         <= '0;
            tail         <= '0;
            buf_cnt      <= '0;
            wr_vld       <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            rd_data      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (vld_p1) begin
                tail <= buf_inc(tail);
            end
            ram_cnt      <= ram_cnt_nxt;
            vld_p1       <= fetch;
            head         <= head_nxt;
            buf_cnt      <= buf_cnt_nxt;
            wr_vld       <= (ram_cnt_nxt != LVL_W'(RAM_WORDS));
            almost_full  <= (int'(lvl_nxt) >= c_AF_THRESH);
            almost_empty <= (int'(lvl_nxt) <= c_AE_THRESH);
            // If the buffer was drained by this pop, the new head is the word arriving now.
            if (buf_cnt_nxt != '0) begin
                rd_data <= (buf_cnt == BUF_CW'(pop)) ? ram_data_p1 : buf_mem[head_nxt];
            end
        end
    end

`ifdef IPML_PFIFO_ERR_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ovf <= 1'b0;
            rd_udf <= 1'b0;
        end else begin
            if (wr_en & ~wr_vld) begin
                wr_ovf <= 1'b1;
            end
            if (rd_en & ~rd_vld) begin
                rd_udf <= 1'b1;
            end
        end
    end
`else
    assign wr_ovf = 1'b0;
    assign rd_udf = 1'b0;
`endif

endmodule

// File: tb/tb_ipml_prefetch_sync_fifo_v2_0.sv
// Scoreboard bench for ipml_prefetch_sync_fifo_v2_0 (prefetch depth 4, 1024-word RAM).
// Expected sticky-flag values follow whether IPML_PFIFO_ERR_FLAG_EN is defined.
module tb_ipml_prefetch_sync_fifo_v2_0;

    localparam int DW  = 10;
    localparam int PD  = 4;
    localparam int AF  = 1000;
    localparam int AE  = 4;
    localparam int CAP = (1 << DW) + PD;
`ifdef IPML_PFIFO_ERR_FLAG_EN
    localparam bit ERR_EXP = 1'b1;
`else
    localparam bit ERR_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_vld;
    logic [31:0] rd_data;
    logic        rd_vld;
    logic [DW:0] water_level;
    logic        almost_full;
    logic        almost_empty;
    logic        wr_ovf;
    logic        rd_udf;

    ipml_prefetch_sync_fifo_v2_0 #(
        .c_DEPTH_WIDTH(DW), .c_DATA_WIDTH(32), .c_PREFETCH_DEPTH(PD),
        .c_AF_THRESH(AF), .c_AE_THRESH(AE)
    ) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_vld(wr_vld),
        .rd_data(rd_data), .rd_en(rd_en), .rd_vld(rd_vld), .water_level(water_level),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .wr_ovf(wr_ovf), .rd_udf(rd_udf)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          pops = 0;
    int          model_cnt = 0;
    bit          chk_en = 1'b0;
    logic [31:0] exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: level/flags against the word-count model, popped data against the scoreboard.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("water_level", water_level, model_cnt);
            chk("almost_full", almost_full, model_cnt >= AF);
            chk("almost_empty", almost_empty, model_cnt <= AE);
            if (rst) begin
                model_cnt = 0;
                exp_q.delete();
            end else begin
                if (rd_en && rd_vld) begin
                    if (exp_q.size() == 0) begin
                        chk("pop_with_empty_scoreboard", 1, 0);
                    end else begin
                        chk("rd_data", rd_data, exp_q.pop_front());
                    end
                    pops++;
                    model_cnt--;
                end
                if (wr_en && wr_vld) model_cnt++;
            end
        end
    end

    task automatic cyc(input bit w, input bit r, input logic [31:0] d);
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        if (w && wr_vld) exp_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_wr_vld"}, wr_vld, 0);
        chk({tag, "_rd_vld"}, rd_vld, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_water_level"}, water_level, 0);
        chk({tag, "_almost_full"}, almost_full, 0);
        chk({tag, "_almost_empty"}, almost_empty, 1);
        chk({tag, "_wr_ovf"}, wr_ovf, 0);
        chk({tag, "_rd_udf"}, rd_udf, 0);
    endtask

    task automatic drain();
        for (int n = 0; n < CAP + 50 && water_level != 0; n++) cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk("drain_level", water_level, 0);
        chk("drain_scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        int wcount;
        int p0;
        int gaps;
        int maxlvl;
        bit started;

        // Reset state
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (2) cyc(0, 0, 0);
        check_reset("reset");
        rst = 1'b0;
        cyc(0, 0, 0);
        chk("wr_vld_after_reset", wr_vld, 1);

        // Single word fall-through: driven after edge 0, visible after edge 3
        cyc(1, 0, 32'hA5A5A5A5);
        chk("single_rd_vld_e1", rd_vld, 0);
        cyc(0, 0, 0);
        chk("single_rd_vld_e2", rd_vld, 0);
        cyc(0, 0, 0);
        chk("single_rd_vld_e3", rd_vld, 1);
        chk("single_rd_data", rd_data, 32'hA5A5A5A5);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk("single_rd_vld_after_pop", rd_vld, 0);
        chk("single_rd_data_held", rd_data, 32'hA5A5A5A5);

        // Fill to capacity, then overflow attempt
        wcount = 0;
        for (int n = 0; n < CAP + 50 && wr_vld; n++) begin
            wcount++;
            cyc(1, 0, n);
        end
        cyc(0, 0, 0);
        chk("fill_accepted", wcount, CAP);
        chk("fill_level", water_level, CAP);
        chk("fill_wr_vld", wr_vld, 0);
        chk("fill_head", rd_data, 0);
        cyc(1, 0, 32'hDEADBEEF);
        cyc(0, 0, 0);
        chk("ovf_flag", wr_ovf, ERR_EXP);
        chk("ovf_level", water_level, CAP);

        // Pop everything back in order
        p0 = pops;
        drain();
        chk("fill_pops", pops - p0, CAP);
        chk("last_rd_data_held", rd_data, CAP - 1);
        chk("udf_clear_before", rd_udf, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk("udf_flag", rd_udf, ERR_EXP);
        repeat (5) cyc(0, 0, 0);
        chk("udf_sticky", rd_udf, ERR_EXP);
        chk("ovf_sticky", wr_ovf, ERR_EXP);

        // Streaming at one word per cycle
        p0 = pops; gaps = 0; maxlvl = 0; started = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            cyc(1, 1, 32'h5000_0000 + i);
            if (rd_vld) started = 1'b1;
            else if (started) gaps++;
            if (int'(water_level) > maxlvl) maxlvl = int'(water_level);
        end
        drain();
        chk("stream_pops", pops - p0, 5000);
        chk("stream_rd_vld_gaps", gaps, 0);
        chk("stream_level_le3", maxlvl <= 3, 1);

        // Random backpressure with pointer wrap
        for (int i = 0; i < 20000; i++) begin
            cyc($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 50, $urandom);
        end
        drain();

        // Reset with words held
        for (int i = 0; i < 10; i++) cyc(1, 0, 32'hC000_0000 + i);
        repeat (4) cyc(0, 0, 0);
        chk("held_level", water_level, 10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset("midreset");
        rst = 1'b0;
        cyc(0, 0, 0);
        chk("wr_vld_after_midreset", wr_vld, 1);
        cyc(1, 0, 32'h1234_5678);
        repeat (3) cyc(0, 0, 0);
        chk("post_reset_head", rd_data, 32'h1234_5678);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
